// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin front end that shares one iterative CORDIC
// engine between NUM_REQ angle sources. One transaction is in flight at a
// time: grant -> issue handshake -> wait for result -> one-cycle response.
// Optional watchdog in WAIT is enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [16*NUM_REQ-1:0]     req_theta,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic signed [15:0]        rsp_sin,
  output logic signed [15:0]        rsp_cos,
  output logic                      rsp_err,
  output logic [15:0]               cor_theta,
  output logic                      cor_in_valid,
  input  logic                      cor_ready,
  input  logic                      cor_out_valid,
  input  logic signed [15:0]        cor_sin,
  input  logic signed [15:0]        cor_cos,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic signed [15:0] rsp_sin_q, rsp_sin_d;
  logic signed [15:0] rsp_cos_q, rsp_cos_d;
  logic [15:0]        cor_theta_q, cor_theta_d;
  logic               cor_in_valid_q, cor_in_valid_d;
  logic               busy_q, busy_d;

  logic               arb_hit;
  logic [ID_W-1:0]    arb_win;
  logic [ID_W-1:0]    arb_cand;
  logic               tmo_hit;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               rsp_err_q, rsp_err_d;

  // Watchdog fires on a WAIT cycle with no result once the limit is reached.
  assign tmo_hit = (state_q == S_WAIT) && !cor_out_valid &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Round-robin search: first valid requester after the pointer, wrapping.
  always_comb begin
    arb_hit  = 1'b0;
    arb_win  = ptr_q;
    arb_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!arb_hit && req_valid[arb_cand]) begin
        arb_hit = 1'b1;
        arb_win = arb_cand;
      end
    end
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q        <= S_IDLE;
      ptr_q          <= ID_W'(NUM_REQ - 1);
      grant_q        <= '0;
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      rsp_sin_q      <= '0;
      rsp_cos_q      <= '0;
      cor_theta_q    <= '0;
      cor_in_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_q        <= grant_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_sin_q      <= rsp_sin_d;
      rsp_cos_q      <= rsp_cos_d;
      cor_theta_q    <= cor_theta_d;
      cor_in_valid_q <= cor_in_valid_d;
      busy_q         <= busy_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      rsp_err_q      <= rsp_err_d;
`endif
    end
  end

  // Next-state: grant only when the engine is idle, leave ISSUE on the
  // handshake, leave WAIT on the first result (or watchdog expiry).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (arb_hit && cor_ready) state_d = S_ISSUE;
      S_ISSUE: if (cor_in_valid_q && cor_ready) state_d = S_WAIT;
      S_WAIT:  if (cor_out_valid || tmo_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; pulses default low, data holds.
  always_comb begin
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    req_ready_d    = '0;
    rsp_valid_d    = '0;
    rsp_sin_d      = rsp_sin_q;
    rsp_cos_d      = rsp_cos_q;
    cor_theta_d    = cor_theta_q;
    cor_in_valid_d = cor_in_valid_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    rsp_err_d      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (arb_hit && cor_ready) begin
          cor_theta_d          = req_theta[16*int'(arb_win) +: 16];
          grant_d              = arb_win;
          ptr_d                = arb_win;
          req_ready_d[arb_win] = 1'b1;
          cor_in_valid_d       = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cor_in_valid_q && cor_ready) begin
          cor_in_valid_d = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
          tmo_cnt_d      = '0;
`endif
        end
      end
      S_WAIT: begin
        if (cor_out_valid) begin
          rsp_sin_d            = cor_sin;
          rsp_cos_d            = cor_cos;
          rsp_valid_d[grant_q] = 1'b1;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_sin_d            = '0;
          rsp_cos_d            = '0;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d            = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_sin      = rsp_sin_q;
  assign rsp_cos      = rsp_cos_q;
  assign cor_theta    = cor_theta_q;
  assign cor_in_valid = cor_in_valid_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter: requesters, a behavioural CORDIC stub with
// random latency, and a transaction-level reference model checked each cycle.
module tb_cordic_arbiter;
  localparam int N = 4;
`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstb;
  logic [N-1:0]        req_valid;
  logic [15:0]         th [N];
  logic [16*N-1:0]     req_theta;
  logic [N-1:0]        req_ready, rsp_valid;
  logic signed [15:0]  rsp_sin, rsp_cos, cor_sin, cor_cos;
  logic                rsp_err, cor_in_valid, cor_ready, cor_out_valid, busy;
  logic [15:0]         cor_theta;
  logic [1:0]          grant_id;

  assign req_theta = {th[3], th[2], th[1], th[0]};

  cordic_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_theta(req_theta),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sin(rsp_sin),
    .rsp_cos(rsp_cos), .rsp_err(rsp_err), .cor_theta(cor_theta),
    .cor_in_valid(cor_in_valid), .cor_ready(cor_ready),
    .cor_out_valid(cor_out_valid), .cor_sin(cor_sin), .cor_cos(cor_cos),
    .busy(busy), .grant_id(grant_id)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // reference model (transaction level)
  int ptr_m, g_m, wait_edges;
  bit outstanding, issuing, waiting;
  logic [15:0] cor_theta_m;
  logic signed [15:0] exp_sin_m, exp_cos_m, rsp_sin_m, rsp_cos_m;

  // observed DUT activity
  int dut_grant_log[$];
  int rsp_id_log[$];
  int rsp_sin_log[$];
  int rsp_cos_log[$];
  int rsp_err_log[$];

  // environment knobs and stub state
  int remaining[N];
  bit rand_mode, mute, force_low, job;
  int lat_fixed, lat, hold;
  logic [15:0] job_theta;
  int n, base_g, base_r;

  function automatic logic signed [15:0] ref_trig(input logic [15:0] t, input bit want_sin);
    real a, v;
    a = 2.0 * 3.14159265358979 * real'(t) / 65536.0;
    v = want_sin ? 32767.0 * $sin(a) : 32767.0 * $cos(a);
    return 16'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
  endfunction

  // winner = valid requester at the smallest circular distance after ptr
  function automatic int rr_pick(input logic [N-1:0] rv, input int ptr);
    int best = -1;
    int bd = N;
    for (int k = 0; k < N; k++) begin
      int d = (k - ptr - 1 + 2 * N) % N;
      if (rv[k] && d < bd) begin
        bd = d;
        best = k;
      end
    end
    return best;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending();
    bit p = outstanding;
    for (int k = 0; k < N; k++) if (remaining[k] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic tick();
    logic [N-1:0] pre_rv, exp_ready, exp_rsp;
    logic pre_cr, pre_cov, pre_civ, pre_rst, exp_err;
    logic [15:0] pre_theta;
    int g;
    pre_rv = req_valid; pre_cr = cor_ready; pre_cov = cor_out_valid;
    pre_civ = cor_in_valid; pre_rst = rstb; pre_theta = cor_theta;
    @(posedge clk);
    #1;
    if (!pre_rst) begin
      ptr_m = N - 1; g_m = 0; outstanding = 0; issuing = 0; waiting = 0;
      cor_theta_m = '0; rsp_sin_m = '0; rsp_cos_m = '0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_sin", 32'(rsp_sin), 0);
      chk("rst_rsp_cos", 32'(rsp_cos), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_cor_theta", 32'(cor_theta), 0);
      chk("rst_cor_in_valid", 32'(cor_in_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
    end else begin
      exp_ready = '0; exp_rsp = '0; exp_err = 1'b0;
      if (waiting) begin
        wait_edges++;
        if (pre_cov) begin
          exp_rsp = N'(1) << g_m; rsp_sin_m = exp_sin_m; rsp_cos_m = exp_cos_m;
          waiting = 0; outstanding = 0;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (wait_edges == TO) begin
          exp_rsp = N'(1) << g_m; exp_err = 1'b1; rsp_sin_m = '0; rsp_cos_m = '0;
          waiting = 0; outstanding = 0;
        end
`endif
      end else if (issuing) begin
        if (pre_cr) begin
          issuing = 0; waiting = 1; wait_edges = 0;
        end
      end else if (!outstanding && pre_rv != '0 && pre_cr) begin
        g = rr_pick(pre_rv, ptr_m);
        exp_ready = N'(1) << g; ptr_m = g; g_m = g;
        outstanding = 1; issuing = 1;
        cor_theta_m = th[g];
        exp_sin_m = ref_trig(th[g], 1'b1);
        exp_cos_m = ref_trig(th[g], 1'b0);
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("busy", 32'(busy), 32'(outstanding));
      chk("cor_in_valid", 32'(cor_in_valid), 32'(issuing));
      chk("grant_id", 32'(grant_id), 32'(g_m));
      chk("cor_theta", 32'(cor_theta), 32'(cor_theta_m));
      chk("rsp_sin", 32'(rsp_sin), 32'(rsp_sin_m));
      chk("rsp_cos", 32'(rsp_cos), 32'(rsp_cos_m));
    end
    if (req_ready != '0) dut_grant_log.push_back(onehot_idx(req_ready));
    if (rsp_valid != '0) begin
      rsp_id_log.push_back(onehot_idx(rsp_valid));
      rsp_sin_log.push_back(int'(rsp_sin));
      rsp_cos_log.push_back(int'(rsp_cos));
      rsp_err_log.push_back(int'(rsp_err));
    end
    // CORDIC stub
    if (pre_civ && pre_cr) begin
      job = 1; job_theta = pre_theta;
      lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
    end else if (cor_out_valid) begin
      hold--;
      if (hold <= 0) begin
        cor_out_valid = 0; job = 0;
        cor_sin = 16'($urandom); cor_cos = 16'($urandom);
      end
    end else if (job && !mute) begin
      if (lat > 1) lat--;
      else begin
        cor_out_valid = 1;
        cor_sin = ref_trig(job_theta, 1'b1);
        cor_cos = ref_trig(job_theta, 1'b0);
        hold = int'($urandom_range(1, 3));
      end
    end
    if (rand_mode) force_low = ($urandom_range(0, 7) == 0);
    cor_ready = !job && !force_low;
    // requesters
    for (int k = 0; k < N; k++) begin
      if (req_ready[k]) begin
        req_valid[k] = 1'b0;
        if (remaining[k] > 0) remaining[k]--;
      end
      if (rand_mode && remaining[k] == 0 && !req_valid[k] && $urandom_range(0, 3) == 0)
        remaining[k] = 1;
      if (!req_valid[k] && remaining[k] > 0) begin
        req_valid[k] = 1'b1;
        th[k] = 16'($urandom);
      end
    end
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int c = 0;
    while (pending() && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(c < budget), 1);
  endtask

  initial begin
    rstb = 0; req_valid = '0; cor_ready = 1; cor_out_valid = 0;
    cor_sin = '0; cor_cos = '0;
    for (int k = 0; k < N; k++) begin th[k] = '0; remaining[k] = 0; end
    rand_mode = 0; mute = 0; force_low = 0; job = 0; lat_fixed = 0; lat = 0; hold = 0;
    job_theta = '0; ptr_m = N - 1; g_m = 0; wait_edges = 0;
    outstanding = 0; issuing = 0; waiting = 0;
    cor_theta_m = '0; exp_sin_m = '0; exp_cos_m = '0; rsp_sin_m = '0; rsp_cos_m = '0;
    repeat (3) tick();
    rstb = 1;
    tick();

    // single requester 0, theta = quarter turn
    base_g = dut_grant_log.size(); base_r = rsp_id_log.size();
    th[0] = 16'h4000; req_valid[0] = 1'b1; remaining[0] = 1;
    wait_quiet("t1_done", 60);
    chk("t1_grant_count", 32'(dut_grant_log.size() - base_g), 1);
    chk("t1_rsp_count", 32'(rsp_id_log.size() - base_r), 1);
    chk("t1_rsp_id", 32'(rsp_id_log[$]), 0);
    chk("t1_sin_near", 32'(iabs(rsp_sin_log[$] - 32767) <= 8), 1);
    chk("t1_cos_near", 32'(iabs(rsp_cos_log[$]) <= 8), 1);
    chk("t1_err", 32'(rsp_err_log[$]), 0);

    // all four at once after reset: order 0,1,2,3
    rstb = 0; tick(); rstb = 1;
    base_g = dut_grant_log.size(); base_r = rsp_id_log.size();
    th[0] = 16'h0000; th[1] = 16'h2000; th[2] = 16'h4000; th[3] = 16'h6000;
    req_valid = 4'hF;
    for (int k = 0; k < N; k++) remaining[k] = 1;
    wait_quiet("t2_done", 120);
    for (int k = 0; k < N; k++) begin
      chk("t2_grant_order", 32'(dut_grant_log[base_g + k]), 32'(k));
      chk("t2_rsp_order", 32'(rsp_id_log[base_r + k]), 32'(k));
    end
    chk("t2_r1_sin", 32'(iabs(rsp_sin_log[base_r + 1] - 23170) <= 8), 1);
    chk("t2_r1_cos", 32'(iabs(rsp_cos_log[base_r + 1] - 23170) <= 8), 1);

    // requesters 1 and 3 continuously valid: strict alternation
    base_g = dut_grant_log.size();
    th[1] = 16'($urandom); th[3] = 16'($urandom);
    req_valid[1] = 1'b1; req_valid[3] = 1'b1; remaining[1] = 3; remaining[3] = 3;
    wait_quiet("t3_done", 200);
    for (int k = 0; k < 6; k++)
      chk("t3_alternate", 32'(dut_grant_log[base_g + k]), (k % 2 == 0) ? 1 : 3);

    // engine not ready: no grant, block stays idle
    force_low = 1; cor_ready = 0;
    base_g = dut_grant_log.size();
    th[2] = 16'($urandom); req_valid[2] = 1'b1; remaining[2] = 1;
    repeat (20) tick();
    chk("t4_no_grant", 32'(dut_grant_log.size() - base_g), 0);
    chk("t4_idle", 32'(busy), 0);
    force_low = 0; cor_ready = 1;
    tick();
    chk("t4_grant_first_edge", 32'(dut_grant_log.size() - base_g), 1);
    chk("t4_grant_id", 32'(dut_grant_log[$]), 2);
    wait_quiet("t4_done", 60);

    // reset during WAIT drops the transaction
    lat_fixed = 12;
    th[0] = 16'($urandom); req_valid[0] = 1'b1; remaining[0] = 1;
    n = 0;
    while (!waiting && n < 20) begin tick(); n++; end
    chk("t5_reach_wait", 32'(waiting), 1);
    tick(); tick();
    base_r = rsp_id_log.size();
    rstb = 0; tick(); rstb = 1;
    repeat (20) tick();
    chk("t5_dropped", 32'(rsp_id_log.size() - base_r), 0);
    lat_fixed = 0;
    th[0] = 16'($urandom); req_valid[0] = 1'b1; remaining[0] = 1;
    wait_quiet("t5_next", 60);
    chk("t5_next_rsp", 32'(rsp_id_log.size() - base_r), 1);
    chk("t5_next_id", 32'(rsp_id_log[$]), 0);

    // random traffic
    base_r = rsp_id_log.size();
    rand_mode = 1;
    repeat (1500) tick();
    rand_mode = 0; force_low = 0;
    wait_quiet("rand_drain", 300);
    chk("rand_activity", 32'(rsp_id_log.size() - base_r > 50), 1);

    // engine never answers
    mute = 1;
    base_r = rsp_id_log.size();
    th[0] = 16'($urandom); req_valid[0] = 1'b1; remaining[0] = 1;
`ifdef CORDIC_ARB_TIMEOUT_EN
    wait_quiet("t6_timeout", 60);
    chk("t6_rsp", 32'(rsp_id_log.size() - base_r), 1);
    chk("t6_err", 32'(rsp_err_log[$]), 1);
    chk("t6_sin0", 32'(rsp_sin_log[$]), 0);
    chk("t6_cos0", 32'(rsp_cos_log[$]), 0);
    mute = 0; job = 0; cor_ready = 1;
    tick();
`else
    repeat (100) tick();
    chk("t6_busy_held", 32'(busy), 1);
    chk("t6_no_rsp", 32'(rsp_id_log.size() - base_r), 0);
    rstb = 0; tick(); rstb = 1;
    mute = 0; job = 0; cor_ready = 1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Shares one iterative cordic engine between NUM_REQ requesters, using round-robin arbitration. Only one transaction is outstanding at a time. The block latches the winner's angle and drives the cordic issue handshake. It then captures sin/cos on the cordic's out_valid and returns the result to the granted requester with a one-cycle per-requester response pulse. It sits between the phase/angle sources (NCOs, rotators) and the single cordic instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; equals clog2(NUM_REQ)
TIMEOUT_CYCLES, 64, watchdog limit in WAIT state (used only with CORDIC_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock; all logic is on the rising edge
rstb  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request; held with theta until the matching req_ready pulse
req_theta  input  16*NUM_REQ  per-requester angle, unsigned Q16 turn (0..65535 = 0..2π); requester k occupies bits [16k+15:16k]
req_ready  output  NUM_REQ  one-cycle accept pulse, at most one bit set
rsp_valid  output  NUM_REQ  one-cycle result pulse to the granted requester, at most one bit set
rsp_sin  output  16  signed Q1.15 sine; valid while any rsp_valid bit is set
rsp_cos  output  16  signed Q1.15 cosine; valid while any rsp_valid bit is set
rsp_err  output  1  high with rsp_valid when the result is a timeout abort
cor_theta  output  16  angle to the cordic
cor_in_valid  output  1  issue strobe to the cordic
cor_ready  input  1  cordic idle/able to accept
cor_out_valid  input  1  cordic result valid (may stay high for more than one cycle)
cor_sin  input  16  cordic sine
cor_cos  input  16  cordic cosine
busy  output  1  high in any state other than IDLE
grant_id  output  ID_W  index of the current/last granted requester

Behaviour:
- Reset (rstb=0 at an edge): state=IDLE.
  - Outputs go to 0: req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, cor_theta, cor_in_valid, busy, grant_id.
  - RR pointer goes to NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction drops the transaction silently. The cordic is not reset by this block.
- All outputs are registered.
- State IDLE:
  - Arbitration runs when any req_valid is set and cor_ready=1.
  - Winner g is the first set req_valid searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - On that edge:
    - latch req_theta[g] into cor_theta
    - grant_id<=g, pointer<=g
    - req_ready[g]<=1 for exactly one cycle
    - cor_in_valid<=1
    - state->ISSUE
  - If cor_ready=0, there is no grant and requests wait.
- State ISSUE:
  - cor_in_valid stays high until an edge where cor_in_valid=1 and cor_ready=1 (the transfer).
  - After the transfer, cor_in_valid<=0 and state->WAIT.
  - The cordic deasserts cor_ready after the transfer.
  - No arbitration in this state.
- State WAIT:
  - On the first edge with cor_out_valid=1:
    - rsp_sin<=cor_sin, rsp_cos<=cor_cos
    - rsp_err<=0, rsp_valid[grant_id]<=1 for one cycle
    - state->IDLE
  - Further cycles of cor_out_valid are ignored in IDLE.
  - rsp_sin/rsp_cos hold their value until the next capture.
- Minimum turnaround is IDLE→ISSUE→WAIT→IDLE plus the cordic latency. A new grant needs cor_ready=1 again.
- Simultaneous requests are resolved by the RR order.
- A requester that drops req_valid before being granted is skipped. This is legal but discouraged.
- A requester re-requesting in the cycle after its req_ready pulse is legal and is treated as a new request.
- Widths: angles and results pass through unmodified. There is no arithmetic on data.

Optional Feature:
Macro: CORDIC_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without cor_out_valid, the block sets rsp_valid[grant_id]=1, rsp_err=1 and rsp_sin=rsp_cos=0, then returns to IDLE.
  - A cor_out_valid arriving on the same edge as the timeout wins, so a normal response is given.
- When not defined:
  - There is no counter.
  - rsp_err is tied to 0.
  - WAIT waits indefinitely.

Test Plan:
1. Reset, then only requester 0 with theta=0x4000 → req_ready[0] pulses once, cor_theta=0x4000 issued. rsp_valid[0] pulses once, with rsp_sin≈32767 and rsp_cos≈0 within ±8 LSB, rsp_err=0.
2. All 4 requesters assert in the same cycle with theta=0x0000/0x2000/0x4000/0x6000 → grant order 0,1,2,3. Each rsp_valid[k] carries its own result (e.g. k=1 gives sin≈cos≈23170 ±8).
3. Requesters 1 and 3 are continuously valid for 6 transactions → grants alternate 1,3,1,3,1,3 and neither is starved.
4. cor_ready held low for 20 cycles while req_valid[2]=1 → no req_ready and busy=0. Grant happens on the first edge after cor_ready rises.
5. rstb pulsed low during WAIT → all outputs 0 next cycle and no rsp_valid for the dropped request. The next request from requester 0 is served normally.
6. With CORDIC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, cor_out_valid forced low → rsp_valid[g]=1 with rsp_err=1 and sin=cos=0 at exactly 16 WAIT cycles. Without the macro, busy stays high.
